// File: rtl/cpu_multicycle_if.sv
// Program-load and observation bundle for cpu_multicycle.
// The master side loads and starts the core; the slave side is the core.
interface cpu_multicycle_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 6
);
    logic              prog_we;
    logic [PC_W-1:0]   prog_addr;
    logic [31:0]       prog_data;
    logic              run;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] alu_result;
    logic              NegativeFlag;
    logic              ZeroFlag;
    logic              halted;

    modport master (
        output prog_we, prog_addr, prog_data, run,
        input  pc, alu_result, NegativeFlag, ZeroFlag, halted
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, run,
        output pc, alu_result, NegativeFlag, ZeroFlag, halted
    );
endinterface

// File: rtl/cpu_multicycle.sv
// Multi-cycle core: FETCH/DECODE/EXEC state machine over a register file,
// ALU, conditional/unconditional jumps, halt and a program-load port.
module cpu_multicycle #(
    parameter int DATA_W   = 32,
    parameter int PM_DEPTH = 64,
    parameter int NREGS    = 8
) (
    input logic             clk,
    input logic             reset,
    cpu_multicycle_if.slave bus
);
    localparam int PC_W  = $clog2(PM_DEPTH);
    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LI   = 4'h6;
    localparam logic [3:0] OP_NOP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hD;
    localparam logic [3:0] OP_BZ   = 4'hE;
    localparam logic [3:0] OP_JMP  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t state_q, state_d;

    logic [31:0]       pmem [PM_DEPTH];
    logic [DATA_W-1:0] rf   [NREGS];

    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] alu_q;
    logic              neg_q;
    logic              zero_q;

    logic [3:0]        op_q;
    logic [IDX_W-1:0]  rd_q;
    logic [IDX_W-1:0]  rs_q;
    logic [15:0]       imm_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic signed [15:0] simm;
    logic [DATA_W-1:0]  sext;
    logic [DATA_W-1:0]  res;
    logic               wr_en;
    logic               take;
    logic               stopped;
    logic               load_en;

    assign stopped = (state_q == S_IDLE) || (state_q == S_HALT);
    assign load_en = bus.prog_we && stopped;
    assign simm    = imm_q;
    assign sext    = DATA_W'(simm);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_HALT: if (bus.run) state_d = S_FETCH;
            S_FETCH:        state_d = S_DECODE;
            S_DECODE:       state_d = S_EXEC;
            S_EXEC:         state_d = (op_q == OP_HALT) ? S_HALT : S_FETCH;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        res   = '0;
        wr_en = 1'b0;
        take  = 1'b0;
        unique case (op_q)
            OP_ADD:  begin res = op_a + op_b; wr_en = 1'b1; end
            OP_SUB:  begin res = op_a - op_b; wr_en = 1'b1; end
            OP_AND:  begin res = op_a & op_b; wr_en = 1'b1; end
            OP_OR:   begin res = op_a | op_b; wr_en = 1'b1; end
            OP_XOR:  begin res = op_a ^ op_b; wr_en = 1'b1; end
            OP_ADDI: begin res = op_b + sext; wr_en = 1'b1; end
            OP_LI:   begin res = sext;        wr_en = 1'b1; end
            OP_BZ:   take = zero_q;
            OP_JMP:  take = 1'b1;
            default: ;
        endcase
    end

    // Program memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (load_en) pmem[bus.prog_addr] <= bus.prog_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= '0;
            alu_q  <= '0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
            op_q   <= OP_NOP;
            rd_q   <= '0;
            rs_q   <= '0;
            imm_q  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_HALT: begin
                    if (bus.run) pc_q <= '0;
                end
                S_FETCH: begin
                    op_q  <= pmem[pc_q][31:28];
                    rd_q  <= pmem[pc_q][24 +: IDX_W];
                    rs_q  <= pmem[pc_q][20 +: IDX_W];
                    imm_q <= pmem[pc_q][15:0];
                end
                S_DECODE: begin
                    op_a <= rf[rd_q];
                    op_b <= rf[rs_q];
                end
                S_EXEC: begin
                    if (wr_en) begin
                        rf[rd_q] <= res;
                        alu_q    <= res;
                        neg_q    <= res[DATA_W-1];
                        zero_q   <= (res == '0);
                    end
                    if (take)                  pc_q <= imm_q[PC_W-1:0];
                    else if (op_q != OP_HALT)  pc_q <= pc_q + PC_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.pc           = pc_q;
    assign bus.alu_result   = alu_q;
    assign bus.NegativeFlag = neg_q;
    assign bus.ZeroFlag     = zero_q;
    assign bus.halted       = (state_q == S_HALT);
endmodule

// File: tb/tb_cpu_multicycle.sv
// Scoreboard bench for cpu_multicycle: a 32-bit/64-word core and a
// 16-bit/8-word core, checked at every rising edge of halted.
module tb_cpu_multicycle;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    always #5 clk = ~clk;

    cpu_multicycle_if #(.DATA_W(32), .PC_W(6)) i0 ();
    cpu_multicycle_if #(.DATA_W(16), .PC_W(3)) i1 ();

    cpu_multicycle #(.DATA_W(32), .PM_DEPTH(64), .NREGS(8)) u0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (i0.slave)
    );

    cpu_multicycle #(.DATA_W(16), .PM_DEPTH(8), .NREGS(8)) u1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (i1.slave)
    );

    typedef struct {
        int          lat;
        int          pc;
        logic [31:0] alu;
        logic        nf;
        logic        zf;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] prg[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_run0   = 0;
    int t_run1   = 0;
    logic h0p    = 1'b0;
    logic h1p    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ins(int op, int rd, int rs, int imm);
        return {op[3:0], rd[3:0], rs[3:0], 4'h0, imm[15:0]};
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever a core enters HALT.
    always @(negedge clk) begin
        exp_t e;
        if (!rst0 && i0.halted && !h0p) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL halt0: unexpected halt at pc %0h", i0.pc);
            end else begin
                e = q0.pop_front();
                chk("pc0", i0.pc, e.pc);
                chk("alu0", i0.alu_result, e.alu);
                chk("nf0", i0.NegativeFlag, e.nf);
                chk("zf0", i0.ZeroFlag, e.zf);
                chk("lat0", cyc - t_run0, e.lat);
            end
        end
        h0p = i0.halted;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst1 && i1.halted && !h1p) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL halt1: unexpected halt at pc %0h", i1.pc);
            end else begin
                e = q1.pop_front();
                chk("pc1", i1.pc, e.pc);
                chk("alu1", {16'h0, i1.alu_result}, e.alu);
                chk("nf1", i1.NegativeFlag, e.nf);
                chk("zf1", i1.ZeroFlag, e.zf);
                chk("lat1", cyc - t_run1, e.lat);
            end
        end
        h1p = i1.halted;
    end

    task automatic wr(int w, int addr, logic [31:0] data, logic go);
        if (w == 0) begin
            i0.prog_we   = 1'b1;
            i0.prog_addr = 6'(addr);
            i0.prog_data = data;
            i0.run       = go;
        end else begin
            i1.prog_we   = 1'b1;
            i1.prog_addr = 3'(addr);
            i1.prog_data = data;
            i1.run       = go;
        end
    endtask

    task automatic idle_bus();
        i0.prog_we = 1'b0;
        i0.run     = 1'b0;
        i1.prog_we = 1'b0;
        i1.run     = 1'b0;
    endtask

    task automatic load(int w, int base);
        foreach (prg[i]) begin
            @(negedge clk);
            wr(w, base + i, prg[i], 1'b0);
        end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic run(int w);
        @(negedge clk);
        if (w == 0) i0.run = 1'b1;
        else        i1.run = 1'b1;
        @(negedge clk);
        idle_bus();
        if (w == 0) t_run0 = cyc;
        else        t_run1 = cyc;
    endtask

    // Writes word 0 in the same cycle as run.
    task automatic load_run0();
        for (int i = 1; i < prg.size(); i++) begin
            @(negedge clk);
            wr(0, i, prg[i], 1'b0);
        end
        @(negedge clk);
        wr(0, 0, prg[0], 1'b1);
        @(negedge clk);
        idle_bus();
        t_run0 = cyc;
    endtask

    task automatic expect_halt(int w, int lat, int pc, logic [31:0] alu,
                               logic nf, logic zf);
        exp_t e;
        e.lat = lat;
        e.pc  = pc;
        e.alu = alu;
        e.nf  = nf;
        e.zf  = zf;
        if (w == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_done(int w);
        int left;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            left = (w == 0) ? q0.size() : q1.size();
            if (left == 0) break;
        end
        left = (w == 0) ? q0.size() : q1.size();
        if (left != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout%0d: %0d halts outstanding, need 0", w, left);
            if (w == 0) q0.delete();
            else        q1.delete();
        end
    endtask

    localparam int LI = 6, ADDI = 5, HLT = 13, BZ = 14, JMP = 15, NOP = 7;

    initial begin
        i0.prog_addr = '0;
        i0.prog_data = '0;
        i1.prog_addr = '0;
        i1.prog_data = '0;
        idle_bus();
        rst0 = 1'b1;
        rst1 = 1'b1;
        #12;
        chk("rst_pc0", i0.pc, 0);
        chk("rst_alu0", i0.alu_result, 0);
        chk("rst_nf0", i0.NegativeFlag, 0);
        chk("rst_zf0", i0.ZeroFlag, 0);
        chk("rst_halt0", i0.halted, 0);
        chk("rst_pc1", i1.pc, 0);
        chk("rst_halt1", i1.halted, 0);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Reset during EXEC of LI r1,5
        prg = '{ins(LI, 1, 0, 5), ins(HLT, 0, 0, 0)};
        load(0, 0);
        run(0);
        @(negedge clk);
        @(negedge clk);
        rst0 = 1'b1;
        #1;
        chk("abort_pc", i0.pc, 0);
        chk("abort_alu", i0.alu_result, 0);
        chk("abort_nf", i0.NegativeFlag, 0);
        chk("abort_zf", i0.ZeroFlag, 0);
        @(negedge clk);
        rst0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_pc", i0.pc, 0);
        chk("idle_halt", i0.halted, 0);

        // r1 must still be 0
        prg = '{ins(LI, 2, 0, 0), ins(0, 2, 1, 0), ins(HLT, 0, 0, 0)};
        load(0, 0);
        expect_halt(0, 9, 2, 32'h0, 1'b0, 1'b1);
        run(0);
        wait_done(0);

        prg = '{ins(LI, 1, 0, 7), ins(LI, 2, 0, 3), ins(1, 1, 2, 0),
                ins(HLT, 0, 0, 0)};
        load(0, 0);
        expect_halt(0, 12, 3, 32'd4, 1'b0, 1'b0);
        run(0);
        wait_done(0);

        // prog_we and run while running are ignored; registers retained
        prg = '{ins(0, 1, 2, 0), ins(HLT, 0, 0, 0)};
        load(0, 0);
        expect_halt(0, 6, 1, 32'd7, 1'b0, 1'b0);
        run(0);
        wr(0, 1, ins(LI, 5, 0, 99), 1'b1);
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        i0.run = 1'b1;
        @(negedge clk);
        idle_bus();
        wait_done(0);

        // Branch taken; word 0 written in the same cycle as run
        prg = '{ins(LI, 1, 0, 2), ins(ADDI, 2, 1, -2), ins(BZ, 0, 0, 5),
                ins(LI, 3, 0, 1), ins(HLT, 0, 0, 0), ins(LI, 3, 0, 9),
                ins(HLT, 0, 0, 0)};
        expect_halt(0, 15, 6, 32'd9, 1'b0, 1'b0);
        load_run0();
        wait_done(0);

        // Branch not taken
        prg = '{ins(LI, 1, 0, 1), ins(BZ, 0, 0, 3), ins(LI, 3, 0, 5),
                ins(HLT, 0, 0, 0)};
        load(0, 0);
        expect_halt(0, 12, 3, 32'd5, 1'b0, 1'b0);
        run(0);
        wait_done(0);

        prg = '{ins(LI, 4, 0, 'h0F0F), ins(LI, 5, 0, 'h00FF), ins(4, 4, 5, 0),
                ins(HLT, 0, 0, 0)};
        load(0, 0);
        expect_halt(0, 12, 3, 32'h0FF0, 1'b0, 1'b0);
        run(0);
        wait_done(0);

        prg = '{ins(2, 4, 5, 0), ins(HLT, 0, 0, 0)};
        load(0, 0);
        expect_halt(0, 6, 1, 32'h00F0, 1'b0, 1'b0);
        run(0);
        wait_done(0);

        prg = '{ins(LI, 6, 0, 'h0F00), ins(3, 4, 6, 0), ins(HLT, 0, 0, 0)};
        load(0, 0);
        expect_halt(0, 9, 2, 32'h0FF0, 1'b0, 1'b0);
        run(0);
        wait_done(0);

        prg = '{ins(LI, 7, 0, 'h8000), ins(ADDI, 7, 7, -1), ins(HLT, 0, 0, 0)};
        load(0, 0);
        expect_halt(0, 9, 2, 32'hFFFF7FFF, 1'b1, 1'b0);
        run(0);
        wait_done(0);

        // 16-bit core: overflow into the sign bit, then wrap to zero
        prg = '{ins(LI, 1, 0, 'h7FFF), ins(LI, 2, 0, 1), ins(0, 1, 2, 0),
                ins(HLT, 0, 0, 0)};
        load(1, 0);
        expect_halt(1, 12, 3, 32'h8000, 1'b1, 1'b0);
        run(1);
        wait_done(1);

        prg = '{ins(0, 1, 1, 0), ins(HLT, 0, 0, 0)};
        load(1, 0);
        expect_halt(1, 6, 1, 32'h0, 1'b0, 1'b1);
        run(1);
        wait_done(1);

        prg = '{ins(NOP, 0, 0, 0), ins(NOP, 0, 0, 0), ins(NOP, 0, 0, 0),
                ins(NOP, 0, 0, 0), ins(NOP, 0, 0, 0), ins(NOP, 0, 0, 0),
                ins(NOP, 0, 0, 0), ins(HLT, 0, 0, 0)};
        load(1, 0);
        expect_halt(1, 24, 7, 32'h0, 1'b0, 1'b1);
        run(1);
        wait_done(1);

        // JMP 0x1F on an 8-word memory lands on 7 and spins there
        prg = '{ins(JMP, 0, 0, 'h1F)};
        load(1, 7);
        run(1);
        repeat (40) @(negedge clk);
        chk("jmp_pc_a", i1.pc, 7);
        chk("jmp_halt", i1.halted, 0);
        repeat (2) @(negedge clk);
        chk("jmp_pc_b", i1.pc, 7);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        chk("rst_again_pc1", i1.pc, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
